// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states, tuser layout and
// the baud divisor used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  localparam int unsigned TUSER_FRAME  = 0;
  localparam int unsigned TUSER_PARITY = 1;
  localparam int unsigned TUSER_BREAK  = 2;
  localparam int unsigned TUSER_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_e;

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, phase reset by restart.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : gen_div_check
    $error("uart_baud_tick: clock too slow for BAUD*OVERSAMPLE");
  end

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_axis.sv
// Oversampled UART receiver with majority-vote sampling, error reporting and a
// single-entry AXI-Stream output register.
module uart_rx_axis
  import uart_pkg::state_e, uart_pkg::IDLE, uart_pkg::START, uart_pkg::DATA;
  import uart_pkg::STOP, uart_pkg::BRK_WAIT, uart_pkg::PAR_NONE, uart_pkg::PAR_ODD;
  import uart_pkg::TUSER_FRAME, uart_pkg::TUSER_PARITY, uart_pkg::TUSER_BREAK;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [2:0]           m_axis_tuser,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned M  = OVERSAMPLE / 2;
  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_LO   = SW'(M - 1);
  localparam logic [SW-1:0] S_MID  = SW'(M);
  localparam logic [SW-1:0] S_HI   = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY > PAR_ODD || STOP_BITS < 1 || STOP_BITS > 2) begin : gen_param_check
    $error("uart_rx_axis: illegal parameter set");
  end

  logic                 rx_meta_q, rx_sync_q;
  logic                 tick, restart;
  state_e               state_q;
  logic [SW-1:0]        s_q;
  logic                 smp_lo_q, smp_mid_q;
  logic [3:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 zero_q, perr_q, ferr_q, brk_q;
  logic                 sampling, dec, maj, exp_par, first_stop, last_stop;
  logic                 frame_err_c, brk_c, commit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Realign the tick phase to the falling start edge.
  assign restart = (state_q == IDLE) && !rx_sync_q;
  assign busy    = (state_q != IDLE);

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    sampling    = (state_q != IDLE) && (state_q != BRK_WAIT);
    dec         = sampling && tick && (s_q == S_HI);
    maj         = (smp_lo_q & smp_mid_q) | (smp_lo_q & rx_sync_q) | (smp_mid_q & rx_sync_q);
    exp_par     = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;
    first_stop  = (bit_idx_q == 4'd0);
    last_stop   = (STOP_BITS == 1) || !first_stop;
    frame_err_c = ferr_q | ~maj;
    // Break is decided on the first stop bit; a second stop bit only adds framing info.
    brk_c       = first_stop ? (zero_q & ~maj) : brk_q;
    commit      = dec && (state_q == STOP) && last_stop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      s_q           <= '0;
      smp_lo_q      <= 1'b0;
      smp_mid_q     <= 1'b0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      zero_q        <= 1'b0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      brk_q         <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= '0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (sampling && tick) begin
        s_q <= (s_q == S_LAST) ? '0 : s_q + 1'b1;
        if (s_q == S_LO)  smp_lo_q  <= rx_sync_q;
        if (s_q == S_MID) smp_mid_q <= rx_sync_q;
      end

      if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
      if (commit) begin
        if (!m_axis_tvalid || m_axis_tready) begin
          m_axis_tvalid              <= 1'b1;
          m_axis_tdata               <= brk_c ? '0 : shift_q;
          m_axis_tuser[TUSER_BREAK]  <= brk_c;
          m_axis_tuser[TUSER_PARITY] <= perr_q;
          m_axis_tuser[TUSER_FRAME]  <= frame_err_c;
        end else begin
          overrun <= 1'b1;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (!rx_sync_q) begin
            state_q <= START;
            s_q     <= '0;
          end
        end
        START: begin
          if (dec) begin
            if (maj) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
              zero_q    <= 1'b1;
              perr_q    <= 1'b0;
              ferr_q    <= 1'b0;
              brk_q     <= 1'b0;
            end
          end
        end
        DATA: begin
          if (dec) begin
            shift_q <= {maj, shift_q[DATA_BITS-1:1]};
            if (maj) zero_q <= 1'b0;
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_q <= '0;
              state_q   <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        uart_pkg::PARITY: begin
          if (dec) begin
            if (maj != exp_par) perr_q <= 1'b1;
            if (maj) zero_q <= 1'b0;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (dec) begin
            if (last_stop) begin
              state_q <= brk_c ? BRK_WAIT : IDLE;
            end else begin
              ferr_q    <= frame_err_c;
              brk_q     <= brk_c;
              bit_idx_q <= 4'd1;
            end
          end
        end
        BRK_WAIT: begin
          if (rx_sync_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
Parametrised, oversampled UART receiver with an AXI-Stream master output; successor to the fixed-format receiver.
- Adds input synchronisation, majority-vote sampling, false-start rejection, optional parity, 1/2 stop bits, and framing/parity/break/overrun reporting.
- Sits between the board RX pin and the AXIS fabric, for example an RX FIFO or a command decoder.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit; even, >=8.
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, stop bits checked: 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- rx  input  1  asynchronous serial line; idles high.
- m_axis_tdata  output  DATA_BITS  received payload, LSB first on the line.
- m_axis_tvalid  output  1  payload valid.
- m_axis_tready  input  1  sink ready.
- m_axis_tuser  output  3  {break, parity_err, frame_err}; qualified by tvalid.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values: tdata=0, tvalid=0, tuser=0, overrun=0, busy=0. Synchroniser flops reset to 1, FSM to IDLE, all counters to 0. Reset mid-frame aborts the frame and discards it.
- rx passes through a 2-flop synchroniser; all sampling uses the synchronised value.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division; elaboration error if DIV<1.
  - Free-running counter 0..DIV-1 emits a one-cycle tick at DIV-1.
  - The counter restarts at 0 when a start edge is seen, so sampling phase aligns to the edge.
- Per-bit sample counter s runs 0..OVERSAMPLE-1 on ticks. Samples are taken at s=M-1, M, M+1, where M=OVERSAMPLE/2. The bit value is the majority of the three, decided at s=M+1.
- FSM states and transitions:
  - IDLE: synchronised rx==0 -> START, s=0.
  - START: at decision, majority==1 -> IDLE (false start, nothing emitted); else -> DATA, bit index 0.
  - DATA: on each decision, shift the bit in LSB first. After bit DATA_BITS-1 -> PARITY if PARITY!=0, else STOP.
  - PARITY: compare the received bit with XOR of the data (even) or its inverse (odd). Mismatch sets parity_err. -> STOP.
  - STOP: each stop decision==0 sets frame_err. After the last stop decision the frame commits. -> IDLE, or -> BRK_WAIT if break.
  - BRK_WAIT: stay until synchronised rx==1 (no tick needed), then -> IDLE.
- Frame timing:
  - Each bit spans OVERSAMPLE ticks.
  - The commit happens mid last stop bit, so a back-to-back start edge is caught.
  - The second stop bit is only checked when STOP_BITS=2.
- Break: every data bit, the parity bit (if present) and the first stop bit sample 0. The frame commits with break=1, frame_err=1, tdata=0.
- Commit and output register:
  - tvalid rises on the clk edge after the final stop decision; that is the output latency.
  - tdata/tuser hold stable while tvalid && !tready.
  - Transfer occurs when tvalid && tready; tvalid drops the next cycle unless a commit happens in that same cycle.
  - Commit in the same cycle as a transfer: the new frame loads and tvalid stays 1.
  - Commit while tvalid && !tready: the new frame is dropped, the old one is kept, overrun pulses for 1 cycle.
- Error frames are still delivered; the sink decides whether to discard them.

Decomposition:
- Shared package uart_pkg holds:
  - Parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - The FSM state enum IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - Tuser bit indices.
  - The divisor function used by both RX and the future TX.
- One sub-module, uart_baud_tick: parameters CLK_FREQ, BAUD, OVERSAMPLE; inputs clk, rst, restart; output tick. It is reused by the transmitter.

Test Plan:
Bench parameters: CLK_FREQ=7_372_800, BAUD=115200, OVERSAMPLE=16, so DIV=4 and a bit is 64 clk.
- 8N1 byte 0xA5 with tready=1 -> one beat, tdata=0xA5, tuser=0, tvalid 1 cycle, about 9.5 bit times after the start edge.
- 8E1 0x03 with correct parity 0, then the same byte with parity bit 1 -> tdata=0x03 tuser=0 for the first; tdata=0x03 tuser=3'b010 for the second.
- 20-clk low glitch on idle rx -> no tvalid, busy returns to 0 within 1 bit time.
- Line held low for 3 frame times, then high -> one beat tdata=0, tuser=3'b101; no further beats until rx high; a following 0x5A is received cleanly.
- tready=0, two back-to-back frames 0x11 then 0x22 -> tdata stays 0x11, one overrun pulse; raising tready gives one transfer of 0x11.
- Reset asserted mid-DATA of 0x7E, released, then 0x3C sent -> outputs at reset values during reset, no partial beat; tdata=0x3C delivered.
